ysyx_22040000_exu_seq: RTL and testbench
========================================

// Module: ysyx_22040000_exu_seq
// PURPOSE
//  Sequencer for the EXU datapath (operand muxes, ALU, branch comparator). Accepts one decoded op from IDU via
//  valid/ready, registers operands and selects, drives the combinational EXU for one cycle, and captures the ALU result.
//  It resolves branches/jumps from the compare flags and presents result + redirect to LSU/WBU via valid/ready.
// PARAMETERS
//  DWIDTH   32   data/address width
// PORTS
//  clk           in   1        clock; all state on rising edge
//  rst_n         in   1        asynchronous, active-low reset
//  flush         in   1        synchronous kill of in-flight op
//  in_valid      in   1        IDU op valid
//  in_ready      out  1        sequencer can accept
//  in_pc/in_rs1/in_rs2/in_imm  in  DWIDTH each  op pc, rs1/rs2 values, immediate
//  in_a_sel      in   A_SEL_LEN     ALU A-operand select (REG/PC)
//  in_b_sel      in   B_SEL_LEN     ALU B-operand select (REG/IMM)
//  in_alu_sel    in   ALUOP_WIDTH   ALU operation
//  in_unsigned   in   1        unsigned compare
//  in_br_type    in   3        br_type_e: NONE/BEQ/BNE/BLT/BGE/JAL/JALR
//  exu_pc/exu_rs1/exu_rs2/exu_imm  out  DWIDTH each  registered operands to EXU
//  exu_a_sel/exu_b_sel/exu_alu_sel/exu_unsigned  out  registered selects to EXU
//  exu_alu_out   in   DWIDTH   EXU ALU result
//  exu_eq/exu_lt in   1 each   EXU compare flags
//  out_valid     out  1        result valid to downstream
//  out_ready     in   1        downstream accepts
//  out_result    out  DWIDTH   writeback value
//  out_pc        out  DWIDTH   pc of op
//  out_redirect  out  1        control transfer taken
//  out_target    out  DWIDTH   redirect target
// BEHAVIOUR
//  - Reset: state=IDLE; every output and operand/result register = 0; in_ready=0 only while rst_n=0.
//  - FSM IDLE -> EXEC -> DONE. IDLE: in_ready=1; in_valid -> latch inputs, go EXEC.
//  - EXEC (exactly 1 cycle): EXU driven only from registers; at clock end capture alu_out/eq/lt products; -> DONE.
//  - DONE: out_valid=1; outputs stable until out_ready. in_ready = out_ready (back-to-back):
//    out_ready&in_valid -> latch new op, EXEC; out_ready&!in_valid -> IDLE; !out_ready -> stay.
//  - Latency: accept at edge N, out_valid high in cycle after edge N+1; throughput 1 op / 2 cycles.
//  - taken: BEQ eq; BNE !eq; BLT lt; BGE !lt; JAL/JALR 1; NONE 0. out_redirect = taken.
//  - out_target = alu_out (JALR: alu_out & ~1). out_result = pc+4 for JAL/JALR, 0 for branches,
//    alu_out for NONE. pc+4 wraps modulo 2^DWIDTH; compare signedness from in_unsigned only.
//  - flush: highest priority; state -> IDLE next edge, out_valid low next cycle, in_ready=0 during flush cycle,
//    op never retires. Async reset mid-op: op lost, no output.
// CONFIGURATION
//  - EXU_SEQ_PERF_EN defined: ports perf_retired, perf_stall (out, 32 each); retired +1 per out_valid&out_ready,
//    stall +1 per DONE&!out_ready cycle; wrap at 2^32; reset 0; flush does not clear.
//  - Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  - Package ysyx_22040000_exu_pkg: br_type_e encoding, seq_state_e, A_SEL/B_SEL/ALUOP widths.
//  - Sub-module ysyx_22040000_br_resolve: combinational (br_type, eq, lt) -> taken, is_jump.
// TESTING
//  - ADD: rs1=5, rs2=7, a=REG b=REG, out_ready=1 -> out_result=12, out_redirect=0, out_valid 2 cycles after accept.
//  - BLT signed: rs1=0xFFFF_FFFF, rs2=1, pc=0x100, imm=0x20 -> redirect=1, target=0x120; unsigned -> redirect=0.
//  - JALR: rs1=0x2003, imm=0, pc=0x80 -> target=0x2002, out_result=0x84, redirect=1.
//  - Backpressure: out_ready=0 for 5 cycles -> outputs stable, in_ready=0; drop to 1 with in_valid -> next op EXEC.
//  - Flush in EXEC and in DONE -> out_valid low next cycle, IDLE, in_ready=1; op not retired.
//  - Async reset mid-EXEC -> all outputs 0; pc wrap 0xFFFF_FFFC JAL -> out_result=0.

Source files
------------

// File: rtl/ysyx_22040000_exu_pkg.sv
// rtl/ysyx_22040000_exu_pkg.sv - shared types and encodings for the EXU sequencer
package ysyx_22040000_exu_pkg;

    localparam int A_SEL_LEN   = 1;
    localparam int B_SEL_LEN   = 1;
    localparam int ALUOP_WIDTH = 4;

    localparam logic [A_SEL_LEN-1:0] A_SEL_REG = 1'b0;
    localparam logic [A_SEL_LEN-1:0] A_SEL_PC  = 1'b1;
    localparam logic [B_SEL_LEN-1:0] B_SEL_REG = 1'b0;
    localparam logic [B_SEL_LEN-1:0] B_SEL_IMM = 1'b1;

    localparam logic [ALUOP_WIDTH-1:0] ALU_ADD = 4'd0;
    localparam logic [ALUOP_WIDTH-1:0] ALU_SUB = 4'd1;
    localparam logic [ALUOP_WIDTH-1:0] ALU_AND = 4'd2;
    localparam logic [ALUOP_WIDTH-1:0] ALU_OR  = 4'd3;
    localparam logic [ALUOP_WIDTH-1:0] ALU_XOR = 4'd4;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BLT  = 3'd3,
        BR_BGE  = 3'd4,
        BR_JAL  = 3'd5,
        BR_JALR = 3'd6
    } br_type_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/ysyx_22040000_br_resolve.sv
// rtl/ysyx_22040000_br_resolve.sv - branch/jump taken decision from EXU compare flags
module ysyx_22040000_br_resolve
    import ysyx_22040000_exu_pkg::*;
(
    input  logic [2:0] i_br_type,
    input  logic       i_eq,
    input  logic       i_lt,
    output logic       o_taken,
    output logic       o_is_jump
);

    always_comb begin
        o_taken   = 1'b0;
        o_is_jump = 1'b0;
        case (i_br_type)
            BR_BEQ:  o_taken = i_eq;
            BR_BNE:  o_taken = ~i_eq;
            BR_BLT:  o_taken = i_lt;
            BR_BGE:  o_taken = ~i_lt;
            BR_JAL, BR_JALR: begin
                o_taken   = 1'b1;
                o_is_jump = 1'b1;
            end
            default: o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/ysyx_22040000_exu_seq.sv
// rtl/ysyx_22040000_exu_seq.sv - EXU sequencer (IDLE/EXEC/DONE); EXU_SEQ_PERF_EN adds perf counters
module ysyx_22040000_exu_seq
    import ysyx_22040000_exu_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DWIDTH-1:0]      in_pc,
    input  logic [DWIDTH-1:0]      in_rs1,
    input  logic [DWIDTH-1:0]      in_rs2,
    input  logic [DWIDTH-1:0]      in_imm,
    input  logic [A_SEL_LEN-1:0]   in_a_sel,
    input  logic [B_SEL_LEN-1:0]   in_b_sel,
    input  logic [ALUOP_WIDTH-1:0] in_alu_sel,
    input  logic                   in_unsigned,
    input  logic [2:0]             in_br_type,
    output logic [DWIDTH-1:0]      exu_pc,
    output logic [DWIDTH-1:0]      exu_rs1,
    output logic [DWIDTH-1:0]      exu_rs2,
    output logic [DWIDTH-1:0]      exu_imm,
    output logic [A_SEL_LEN-1:0]   exu_a_sel,
    output logic [B_SEL_LEN-1:0]   exu_b_sel,
    output logic [ALUOP_WIDTH-1:0] exu_alu_sel,
    output logic                   exu_unsigned,
    input  logic [DWIDTH-1:0]      exu_alu_out,
    input  logic                   exu_eq,
    input  logic                   exu_lt,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DWIDTH-1:0]      out_result,
    output logic [DWIDTH-1:0]      out_pc,
    output logic                   out_redirect,
    output logic [DWIDTH-1:0]      out_target
`ifdef EXU_SEQ_PERF_EN
    ,
    output logic [31:0]            perf_retired,
    output logic [31:0]            perf_stall
`endif
);

    localparam logic [DWIDTH-1:0] PC_STEP = DWIDTH'(4);

    seq_state_e             r_state;
    seq_state_e             w_next;
    logic                   w_accept;
    logic                   w_taken;
    logic                   w_is_jump;
    logic [DWIDTH-1:0]      w_result;
    logic [DWIDTH-1:0]      w_target;

    logic [DWIDTH-1:0]      r_pc, r_rs1, r_rs2, r_imm;
    logic [A_SEL_LEN-1:0]   r_a_sel;
    logic [B_SEL_LEN-1:0]   r_b_sel;
    logic [ALUOP_WIDTH-1:0] r_alu_sel;
    logic                   r_unsigned;
    logic [2:0]             r_br_type;

    logic [DWIDTH-1:0]      r_out_result, r_out_pc, r_out_target;
    logic                   r_out_redirect;

    // Flush blocks acceptance so a killed cycle can never start a new op.
    assign in_ready = rst_n & ~flush &
                      ((r_state == S_IDLE) | ((r_state == S_DONE) & out_ready));
    assign w_accept = in_valid & in_ready;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_EXEC;
            S_EXEC: w_next = S_DONE;
            S_DONE: if (out_ready) w_next = w_accept ? S_EXEC : S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (flush) w_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_imm      <= '0;
            r_a_sel    <= '0;
            r_b_sel    <= '0;
            r_alu_sel  <= '0;
            r_unsigned <= 1'b0;
            r_br_type  <= '0;
        end else if (w_accept) begin
            r_pc       <= in_pc;
            r_rs1      <= in_rs1;
            r_rs2      <= in_rs2;
            r_imm      <= in_imm;
            r_a_sel    <= in_a_sel;
            r_b_sel    <= in_b_sel;
            r_alu_sel  <= in_alu_sel;
            r_unsigned <= in_unsigned;
            r_br_type  <= in_br_type;
        end
    end

    ysyx_22040000_br_resolve u_br_resolve (
        .i_br_type (r_br_type),
        .i_eq      (exu_eq),
        .i_lt      (exu_lt),
        .o_taken   (w_taken),
        .o_is_jump (w_is_jump)
    );

    always_comb begin
        w_target = exu_alu_out;
        if (r_br_type == BR_JALR) w_target = {exu_alu_out[DWIDTH-1:1], 1'b0};
        if (w_is_jump)                  w_result = r_pc + PC_STEP;
        else if (r_br_type == BR_NONE)  w_result = exu_alu_out;
        else                            w_result = '0;
    end

    // Results are frozen at the end of EXEC so DONE outputs stay stable under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_result   <= '0;
            r_out_pc       <= '0;
            r_out_target   <= '0;
            r_out_redirect <= 1'b0;
        end else if (r_state == S_EXEC) begin
            r_out_result   <= w_result;
            r_out_pc       <= r_pc;
            r_out_target   <= w_target;
            r_out_redirect <= w_taken;
        end
    end

    assign exu_pc       = r_pc;
    assign exu_rs1      = r_rs1;
    assign exu_rs2      = r_rs2;
    assign exu_imm      = r_imm;
    assign exu_a_sel    = r_a_sel;
    assign exu_b_sel    = r_b_sel;
    assign exu_alu_sel  = r_alu_sel;
    assign exu_unsigned = r_unsigned;

    assign out_valid    = (r_state == S_DONE);
    assign out_result   = r_out_result;
    assign out_pc       = r_out_pc;
    assign out_target   = r_out_target;
    assign out_redirect = r_out_redirect;

`ifdef EXU_SEQ_PERF_EN
    logic [31:0] r_perf_retired;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_retired <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (out_valid & out_ready & ~flush) r_perf_retired <= r_perf_retired + 32'd1;
            if (out_valid & ~out_ready)         r_perf_stall   <= r_perf_stall + 32'd1;
        end
    end

    assign perf_retired = r_perf_retired;
    assign perf_stall   = r_perf_stall;
`endif

endmodule

// File: tb/tb_ysyx_22040000_exu_seq.sv
// tb/tb_ysyx_22040000_exu_seq.sv - self-checking bench for ysyx_22040000_exu_seq
module tb_ysyx_22040000_exu_seq;
    import ysyx_22040000_exu_pkg::*;

    logic        clk, rst_n, flush, in_valid, in_ready;
    logic [31:0] in_pc, in_rs1, in_rs2, in_imm;
    logic        in_a_sel, in_b_sel, in_unsigned;
    logic [3:0]  in_alu_sel;
    logic [2:0]  in_br_type;
    logic [31:0] exu_pc, exu_rs1, exu_rs2, exu_imm, exu_alu_out;
    logic        exu_a_sel, exu_b_sel, exu_unsigned, exu_eq, exu_lt;
    logic [3:0]  exu_alu_sel;
    logic        out_valid, out_ready, out_redirect;
    logic [31:0] out_result, out_pc, out_target;
`ifdef EXU_SEQ_PERF_EN
    logic [31:0] perf_retired, perf_stall;
`endif

    ysyx_22040000_exu_seq #(.DWIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_a_sel(in_a_sel), .in_b_sel(in_b_sel), .in_alu_sel(in_alu_sel),
        .in_unsigned(in_unsigned), .in_br_type(in_br_type),
        .exu_pc(exu_pc), .exu_rs1(exu_rs1), .exu_rs2(exu_rs2), .exu_imm(exu_imm),
        .exu_a_sel(exu_a_sel), .exu_b_sel(exu_b_sel), .exu_alu_sel(exu_alu_sel),
        .exu_unsigned(exu_unsigned), .exu_alu_out(exu_alu_out),
        .exu_eq(exu_eq), .exu_lt(exu_lt),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_pc(out_pc), .out_redirect(out_redirect), .out_target(out_target)
`ifdef EXU_SEQ_PERF_EN
        , .perf_retired(perf_retired), .perf_stall(perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            default: return a + b;
        endcase
    endfunction

    // Combinational EXU stand-in, fed only from the sequencer's registered operands.
    assign exu_alu_out = alu_f(exu_alu_sel, exu_a_sel ? exu_pc : exu_rs1, exu_b_sel ? exu_imm : exu_rs2);
    assign exu_eq      = (exu_rs1 == exu_rs2);
    assign exu_lt      = exu_unsigned ? (exu_rs1 < exu_rs2) : ($signed(exu_rs1) < $signed(exu_rs2));

    typedef struct packed {
        logic [31:0] pc, rs1, rs2, imm;
        logic        a_sel, b_sel;
        logic [3:0]  alu;
        logic        uns;
        logic [2:0]  br;
    } op_t;

    typedef struct {
        op_t         op;
        logic [31:0] exp_result;
        logic [31:0] exp_target;
        logic        exp_redirect;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vq[$];
    op_t  sb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add_vec(input logic [31:0] pc, rs1, rs2, imm, input logic a, b,
                           input logic [3:0] alu, input logic uns, input logic [2:0] br,
                           input logic [31:0] er, et, input logic ered);
        vec_t v;
        v.op = '{pc: pc, rs1: rs1, rs2: rs2, imm: imm, a_sel: a, b_sel: b, alu: alu, uns: uns, br: br};
        v.exp_result = er; v.exp_target = et; v.exp_redirect = ered;
        vq.push_back(v);
    endtask

    task automatic apply_op(input op_t o);
        in_pc = o.pc; in_rs1 = o.rs1; in_rs2 = o.rs2; in_imm = o.imm;
        in_a_sel = o.a_sel; in_b_sel = o.b_sel; in_alu_sel = o.alu;
        in_unsigned = o.uns; in_br_type = o.br;
    endtask

    // Reference: the architectural outcome of one op computed directly from its fields.
    function automatic void model(input op_t o, output logic [31:0] res, output logic [31:0] tgt, output logic red);
        logic [31:0] a, b, sum;
        logic        lt;
        a   = o.a_sel ? o.pc : o.rs1;
        b   = o.b_sel ? o.imm : o.rs2;
        sum = alu_f(o.alu, a, b);
        lt  = o.uns ? (o.rs1 < o.rs2) : ($signed(o.rs1) < $signed(o.rs2));
        case (o.br)
            3'd1: red = (o.rs1 == o.rs2);
            3'd2: red = (o.rs1 != o.rs2);
            3'd3: red = lt;
            3'd4: red = !lt;
            3'd5, 3'd6: red = 1'b1;
            default: red = 1'b0;
        endcase
        tgt = (o.br == 3'd6) ? (sum & 32'hFFFF_FFFE) : sum;
        if (o.br == 3'd5 || o.br == 3'd6) res = o.pc + 32'd4;
        else if (o.br == 3'd0)            res = sum;
        else                              res = 32'd0;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        @(negedge clk);
        apply_op(v.op);
        in_valid = 1'b1;
        #1 chk($sformatf("v%0d in_ready", idx), {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("v%0d latency", idx), n, 32'd2);
        chk($sformatf("v%0d result", idx), out_result, v.exp_result);
        chk($sformatf("v%0d target", idx), out_target, v.exp_target);
        chk($sformatf("v%0d redirect", idx), {31'd0, out_redirect}, {31'd0, v.exp_redirect});
        chk($sformatf("v%0d pc", idx), out_pc, v.op.pc);
    endtask

    initial begin
        op_t         o, p;
        logic [31:0] er, et;
        logic        ered;
        int          retired, stalls, n;
`ifdef EXU_SEQ_PERF_EN
        logic [31:0] snap_ret, snap_stall;
`endif
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        apply_op('0);

        add_vec(32'h0,         32'd5,         32'd7, 32'h0,         A_SEL_REG, B_SEL_REG, ALU_ADD, 1'b0, BR_NONE, 32'd12,        32'd12,        1'b0);
        add_vec(32'h100,       32'hFFFF_FFFF, 32'd1, 32'h20,        A_SEL_PC,  B_SEL_IMM, ALU_ADD, 1'b0, BR_BLT,  32'd0,         32'h120,       1'b1);
        add_vec(32'h100,       32'hFFFF_FFFF, 32'd1, 32'h20,        A_SEL_PC,  B_SEL_IMM, ALU_ADD, 1'b1, BR_BLT,  32'd0,         32'h120,       1'b0);
        add_vec(32'h80,        32'h2003,      32'd0, 32'h0,         A_SEL_REG, B_SEL_IMM, ALU_ADD, 1'b0, BR_JALR, 32'h84,        32'h2002,      1'b1);
        add_vec(32'hFFFF_FFFC, 32'd0,         32'd0, 32'h8,         A_SEL_PC,  B_SEL_IMM, ALU_ADD, 1'b0, BR_JAL,  32'd0,         32'd4,         1'b1);
        add_vec(32'h200,       32'h55,        32'h55, 32'hFFFF_FFF0, A_SEL_PC, B_SEL_IMM, ALU_ADD, 1'b0, BR_BEQ,  32'd0,         32'h1F0,       1'b1);
        add_vec(32'h200,       32'h55,        32'h55, 32'hFFFF_FFF0, A_SEL_PC, B_SEL_IMM, ALU_ADD, 1'b0, BR_BNE,  32'd0,         32'h1F0,       1'b0);
        add_vec(32'h40,        32'h8000_0000, 32'd0, 32'h10,        A_SEL_PC,  B_SEL_IMM, ALU_ADD, 1'b0, BR_BGE,  32'd0,         32'h50,        1'b0);
        add_vec(32'h40,        32'h8000_0000, 32'd0, 32'h10,        A_SEL_PC,  B_SEL_IMM, ALU_ADD, 1'b1, BR_BGE,  32'd0,         32'h50,        1'b1);
        add_vec(32'h0,         32'd3,         32'd5, 32'h0,         A_SEL_REG, B_SEL_REG, ALU_SUB, 1'b0, BR_NONE, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b0);
        add_vec(32'h0,         32'hF0F0,      32'd0, 32'h0FF0,      A_SEL_REG, B_SEL_IMM, ALU_XOR, 1'b0, BR_NONE, 32'hFF00,      32'hFF00,      1'b0);

        #12;
        chk("rst in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst out_result", out_result, 32'd0);
        chk("rst out_target", out_target, 32'd0);
        chk("rst exu_rs1", exu_rs1, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("idle in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < vq.size(); i++) run_vec(vq[i], i);

        // Backpressure: hold DONE for 5 cycles, then release with the next op waiting.
        @(negedge clk);
        out_ready = 1'b0;
        apply_op(vq[0].op);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        apply_op(vq[9].op);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("bp out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp out_result", out_result, 32'd12);
            chk("bp in_ready", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1 chk("bp release in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp next exec out_valid", {31'd0, out_valid}, 32'd0);
        chk("bp next exu_rs1", exu_rs1, 32'd3);
        @(negedge clk);
        chk("bp next out_valid", {31'd0, out_valid}, 32'd1);
        chk("bp next out_result", out_result, 32'hFFFF_FFFE);

        // Flush during EXEC.
        @(negedge clk);
        apply_op(vq[3].op);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b1;
        #1 chk("flx in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        #1 chk("flx out_valid", {31'd0, out_valid}, 32'd0);
        chk("flx in_ready idle", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        chk("flx no retire", {31'd0, out_valid}, 32'd0);

        // Flush during DONE.
        out_ready = 1'b0;
        apply_op(vq[4].op);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("fld done", {31'd0, out_valid}, 32'd1);
        flush = 1'b1;
        #1 chk("fld in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        #1 chk("fld out_valid", {31'd0, out_valid}, 32'd0);
        chk("fld in_ready idle", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        chk("fld no retire", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;

        // Asynchronous reset while in EXEC.
        apply_op(vq[4].op);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("ar out_valid", {31'd0, out_valid}, 32'd0);
        chk("ar out_result", out_result, 32'd0);
        chk("ar out_target", out_target, 32'd0);
        chk("ar out_pc", out_pc, 32'd0);
        chk("ar out_redirect", {31'd0, out_redirect}, 32'd0);
        chk("ar in_ready", {31'd0, in_ready}, 32'd0);
        chk("ar exu_pc", exu_pc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ar post out_valid", {31'd0, out_valid}, 32'd0);
        chk("ar post in_ready", {31'd0, in_ready}, 32'd1);

        // Randomized traffic against the reference model.
        retired = 0;
        stalls  = 0;
`ifdef EXU_SEQ_PERF_EN
        snap_ret   = perf_retired;
        snap_stall = perf_stall;
`endif
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            o.pc    = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            o.rs1   = $urandom;
            o.rs2   = ($urandom_range(0, 3) == 0) ? o.rs1 : $urandom;
            o.imm   = $urandom;
            o.a_sel = 1'($urandom_range(0, 1));
            o.b_sel = 1'($urandom_range(0, 1));
            o.alu   = 4'($urandom_range(0, 4));
            o.uns   = 1'($urandom_range(0, 1));
            o.br    = 3'($urandom_range(0, 6));
            apply_op(o);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && !out_ready) stalls++;
            if (out_valid && out_ready) begin
                retired++;
                if (sb.size() == 0) begin
                    chk("rnd unexpected retire", 32'd1, 32'd0);
                end else begin
                    p = sb.pop_front();
                    model(p, er, et, ered);
                    chk("rnd result", out_result, er);
                    chk("rnd target", out_target, et);
                    chk("rnd redirect", {31'd0, out_redirect}, {31'd0, ered});
                    chk("rnd pc", out_pc, p.pc);
                end
            end
            if (in_valid && in_ready) sb.push_back(o);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 10) begin
            #1;
            if (out_valid) begin
                retired++;
                p = sb.pop_front();
                model(p, er, et, ered);
                chk("drain result", out_result, er);
                chk("drain target", out_target, et);
            end
            @(negedge clk);
            n++;
        end
        chk("drain empty", sb.size(), 32'd0);
`ifdef EXU_SEQ_PERF_EN
        @(negedge clk);
        chk("perf retired", perf_retired - snap_ret, retired);
        chk("perf stall", perf_stall - snap_stall, stalls);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
